// File: rtl/ipic_pkg.sv
// Shared definitions for the IPIC command sequencer.
//  - IPIC engine command codes and the engine idle state code.
//  - Sequencer FSM state encoding.
//  - A helper that says whether a command type can be issued to the engine.
package ipic_pkg;

  localparam logic [2:0] IPIC_SINGLE_RD = 3'd2;
  localparam logic [2:0] IPIC_SINGLE_WR = 3'd3;
  localparam logic [3:0] IPIC_ST_IDLE   = 4'd0;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_BUSY  = 2'd2,
    SEQ_RESP  = 2'd3
  } seq_state_e;

  function automatic logic is_supported(input logic [2:0] t);
    return (t == IPIC_SINGLE_RD) || (t == IPIC_SINGLE_WR);
  endfunction

endpackage

// File: rtl/ipic_cmd_fifo.sv
// Synchronous command FIFO for the IPIC sequencer.
//  Pointers carry one extra wrap bit: equal pointers mean empty, pointers
//  that differ only in the wrap bit mean full. A push and a pop in the same
//  cycle are both honoured. dout shows the head entry combinationally.
// Ports:
//  clk, reset   clock, synchronous active-high reset (empties the FIFO)
//  push, din    write request and data (ignored when full)
//  pop          read request (ignored when empty)
//  dout         head entry
//  full, empty  occupancy flags
module ipic_cmd_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ipic_cmd_sequencer.sv
// IPIC command sequencer: queues register read/write commands in a small
// FIFO and issues them one at a time to the IPIC lite engine over the
// ipic_start/ipic_done interface, returning each result on a response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds valid and its payload stable until that edge;
// cmd_ready is !full, rsp_valid stays high with rsp_* frozen until rsp_ready.
//
// Optional feature macro: IPIC_CMD_TIMEOUT_EN adds a watchdog that ends an
// ISSUE/BUSY wait after TIMEOUT_CYC cycles with rsp_err=1 and rsp_rdata=0.
//
// Ports:
//  clk, reset                  clock, synchronous active-high reset
//  cmd_valid/ready/type/addr/wdata   command input channel
//  rsp_valid/ready/rdata/err   response output channel
//  ipic_type, ipic_start, read_addr, write_addr, write_data  to engine
//  ipic_done, single_read_data, ipic_state                   from engine
//  dbg_state                   current sequencer FSM state
module ipic_cmd_sequencer
  import ipic_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_type,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [2:0]            ipic_type,
  output logic                  ipic_start,
  input  logic                  ipic_done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] single_read_data,
  input  logic [3:0]            ipic_state,
  output logic [1:0]            dbg_state
);

  localparam int FW = 3 + ADDR_WIDTH + DATA_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic [FW-1:0]         fifo_din;
  logic [FW-1:0]         fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [2:0]            head_type;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [2:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  done_q;
  logic                  done_rise;
  logic                  timeout;

  assign fifo_din = {cmd_type, cmd_addr, cmd_wdata};
  assign {head_type, head_addr, head_wdata} = fifo_dout;

  // The head is taken as soon as the FSM is idle, so issue latency is one cycle.
  assign fifo_pop  = (state_q == SEQ_IDLE) && !fifo_empty;
  assign done_rise = ipic_done && !done_q;

  ipic_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef IPIC_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt;

  // Counts cycles spent waiting on the engine; cleared in every other state.
  always_ff @(posedge clk) begin
    if (reset || !(state_q == SEQ_ISSUE || state_q == SEQ_BUSY)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign timeout = (state_q == SEQ_ISSUE || state_q == SEQ_BUSY) &&
                   (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) state_d = is_supported(head_type) ? SEQ_ISSUE : SEQ_RESP;
      end
      SEQ_ISSUE: begin
        if (timeout)                         state_d = SEQ_RESP;
        else if (ipic_state != IPIC_ST_IDLE) state_d = SEQ_BUSY;
      end
      SEQ_BUSY: begin
        if (timeout || done_rise) state_d = SEQ_RESP;
      end
      SEQ_RESP: begin
        if (rsp_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Command register and response capture. Engine-facing values only change
  // when a supported command leaves IDLE, so they are frozen through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= ipic_done;
      case (state_q)
        SEQ_IDLE: begin
          if (fifo_pop) begin
            rdata_q <= '0;
            err_q   <= !is_supported(head_type);
            if (is_supported(head_type)) begin
              type_q  <= head_type;
              addr_q  <= head_addr;
              wdata_q <= head_wdata;
            end
          end
        end
        SEQ_ISSUE, SEQ_BUSY: begin
          if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (state_q == SEQ_BUSY && done_rise && type_q == IPIC_SINGLE_RD) begin
            rdata_q <= single_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    ipic_start = (state_q == SEQ_ISSUE);
    rsp_valid  = (state_q == SEQ_RESP);
    cmd_ready  = !fifo_full;
    rsp_rdata  = rdata_q;
    rsp_err    = err_q;
    ipic_type  = type_q;
    read_addr  = addr_q;
    write_addr = addr_q;
    write_data = wdata_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_ipic_cmd_sequencer.sv
// Testbench for ipic_cmd_sequencer: directed scenarios plus randomized
// traffic against a behavioural engine and an in-order response model.
module tb_ipic_cmd_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [2:0]    ipic_type;
  logic          ipic_start;
  logic          ipic_done;
  logic [AW-1:0] read_addr;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] single_read_data;
  logic [3:0]    ipic_state;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  ipic_cmd_sequencer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_type         (cmd_type),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .ipic_type        (ipic_type),
    .ipic_start       (ipic_start),
    .ipic_done        (ipic_done),
    .read_addr        (read_addr),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .single_read_data (single_read_data),
    .ipic_state       (ipic_state),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Entries are {type, addr, wdata}.
  logic [66:0] exp_q[$];    // every accepted command, response order
  logic [66:0] issue_q[$];  // accepted supported commands, engine order
  logic [31:0] rd_q[$];     // read data returned by the engine, in order
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_starts = 0;
  logic [31:0] last_rsp_data;
  logic        last_rsp_err;

  // engine model controls
  int          eng_phase = 0;
  int          eng_lat   = 0;
  logic [66:0] eng_cur;
  bit          eng_stall = 0;
  bit          eng_hang  = 0;
  bit          eng_abort = 0;
  bit          eng_fixed = 0;
  logic [31:0] eng_fixed_val = 32'h0;
  bit          to_mode   = 0;
  bit          rsp_rand  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit good_type(input logic [2:0] t);
    return (t == 3'd2) || (t == 3'd3);
  endfunction

  // ---------------- command acceptance monitor ----------------
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      exp_q.push_back({cmd_type, cmd_addr, cmd_wdata});
      if (good_type(cmd_type)) issue_q.push_back({cmd_type, cmd_addr, cmd_wdata});
    end
  end

  // ---------------- behavioural IPIC engine ----------------
  initial begin
    ipic_done = 1'b0;
    ipic_state = 4'd0;
    single_read_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        eng_phase = 0;
        ipic_done = 1'b0;
        ipic_state = 4'd0;
      end else begin
        case (eng_phase)
          0: begin
            if (ipic_start && !eng_stall) begin
              n_starts++;
              if (issue_q.size() == 0) begin
                check("unexpected_start", 64'(ipic_start), 64'd0);
              end else begin
                eng_cur = issue_q.pop_front();
                check("issue_type", 64'(ipic_type), 64'(eng_cur[66:64]));
                check("issue_addr", 64'(read_addr), 64'(eng_cur[63:32]));
                ipic_state = 4'd1;
                eng_lat = $urandom_range(1, 6);
                eng_phase = 1;
              end
            end
          end
          1: begin
            if (eng_abort) begin
              eng_abort = 0;
              ipic_state = 4'd0;
              eng_phase = 0;
            end else begin
              if (eng_lat == 6 + 100) eng_lat = 0;
              if (!eng_hang) begin
                eng_lat--;
                if (eng_lat <= 0) begin
                  ipic_done = 1'b1;
                  single_read_data = eng_fixed ? eng_fixed_val : $urandom;
                  if (eng_cur[66:64] == 3'd2) rd_q.push_back(single_read_data);
                  check("hold_type", 64'(ipic_type), 64'(eng_cur[66:64]));
                  check("hold_waddr", 64'(write_addr), 64'(eng_cur[63:32]));
                  if (eng_cur[66:64] == 3'd3)
                    check("hold_wdata", 64'(write_data), 64'(eng_cur[31:0]));
                  eng_phase = 2;
                end
              end
              if (eng_phase == 1 || eng_phase == 2) begin
                // Start must be gone one cycle after the engine left idle.
                check("start_dropped", 64'(ipic_start), 64'd0);
              end
            end
          end
          default: begin
            ipic_done = 1'b0;
            ipic_state = 4'd0;
            single_read_data = $urandom;
            eng_phase = 0;
          end
        endcase
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [66:0] e;
    logic        x_err;
    logic [31:0] x_data;
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q[0];
        x_err = 1'b0;
        x_data = 32'h0;
        if (!good_type(e[66:64]) || to_mode) x_err = 1'b1;
        else if (e[66:64] == 3'd2) begin
          if (rd_q.size() == 0) check("rsp_no_read_data", 64'(rsp_valid), 64'd0);
          else x_data = rd_q[0];
        end
        check("rsp_err", 64'(rsp_err), 64'(x_err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(x_data));
        check("rsp_no_start", 64'(ipic_start), 64'd0);
        if (rsp_ready) begin
          last_rsp_data = rsp_rdata;
          last_rsp_err = rsp_err;
          void'(exp_q.pop_front());
          if (e[66:64] == 3'd2 && !to_mode && rd_q.size() > 0) void'(rd_q.pop_front());
        end
      end
    end
  end

  // ---------------- random response back-pressure ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rsp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    issue_q.delete();
    rd_q.delete();
    #1;
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_type = t;
    cmd_addr = a;
    cmd_wdata = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [2:0] rand_type();
    int r = $urandom_range(0, 9);
    logic [2:0] t;
    if (r < 4) return 3'd2;
    if (r < 8) return 3'd3;
    t = 3'($urandom_range(0, 7));
    if (good_type(t)) t = 3'd7;
    return t;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int starts0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_type = 3'd0;
    cmd_addr = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    reset_dut();

    // reset state
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ipic_start", 64'(ipic_start), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_ipic_type", 64'(ipic_type), 64'd0);
    check("rst_read_addr", 64'(read_addr), 64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;

    // single read
    eng_fixed = 1;
    eng_fixed_val = 32'hDEAD_BEEF;
    send_cmd(3'd2, 32'h4000_0010, 32'h0);
    wait_idle(100);
    check("read_data", 64'(last_rsp_data), 64'hDEAD_BEEF);
    check("read_err", 64'(last_rsp_err), 64'd0);
    eng_fixed = 0;

    // single write
    send_cmd(3'd3, 32'h4000_0004, 32'h1234_5678);
    wait_idle(100);
    check("write_rdata", 64'(last_rsp_data), 64'd0);
    check("write_err", 64'(last_rsp_err), 64'd0);

    // unsupported type
    starts0 = n_starts;
    send_cmd(3'd0, 32'h4000_0020, 32'h5555_AAAA);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("bad_type_rsp_quick", 64'(seen), 64'd1);
    wait_idle(50);
    check("bad_type_err", 64'(last_rsp_err), 64'd1);
    check("bad_type_no_start", 64'(n_starts), 64'(starts0));

    // response stall, then back-pressure with a stalled engine
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    send_cmd(3'd2, 32'h4000_0030, 32'h0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("stall_rsp_seen", 64'(seen), 64'd1);
    eng_stall = 1;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      send_cmd(i[0] ? 3'd3 : 3'd2, 32'h4000_0100 + 32'(i * 4), $urandom);
    @(negedge clk);
    check("fifo_full_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    eng_stall = 0;
    send_cmd(3'd3, 32'h4000_0200, 32'hCAFE_0005);
    wait_idle(300);

    // randomized traffic
    rsp_rand = 1;
    for (int i = 0; i < 40; i++) begin
      send_cmd(rand_type(), $urandom, $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle(2000);
    rsp_rand = 0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;

    // reset while the engine is busy
    eng_hang = 1;
    send_cmd(3'd2, 32'h4000_0300, 32'h0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (eng_phase == 1 && dbg_state == 2'd2) begin
        seen = 1;
        break;
      end
    end
    check("reached_busy", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    reset_dut();
    eng_hang = 0;
    @(negedge clk);
    check("rst_busy_state", 64'(dbg_state), 64'd0);
    check("rst_busy_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    send_cmd(3'd3, 32'h4000_0400, 32'h0BAD_F00D);
    wait_idle(100);
    check("post_rst_err", 64'(last_rsp_err), 64'd0);

`ifdef IPIC_CMD_TIMEOUT_EN
    // hung engine recovered by the watchdog
    eng_hang = 1;
    to_mode = 1;
    send_cmd(3'd2, 32'h4000_0500, 32'h0);
    wait_idle(100);
    check("timeout_err", 64'(last_rsp_err), 64'd1);
    check("timeout_rdata", 64'(last_rsp_data), 64'd0);
    to_mode = 0;
    eng_hang = 0;
    eng_abort = 1;
    repeat (3) @(posedge clk);
    #1;
`endif

    check("queues_empty", 64'(exp_q.size() + issue_q.size() + rd_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "global timeout");
  end

endmodule
